// File: rtl/nibble_add_pkg.sv
// Shared types for the nibble-serial adder controller.
// Nibble width and the IDLE/RUN/DONE state encoding.
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_adder.sv
// 4-bit ripple-carry adder slice, purely combinational.
// Ports: a, b (nibbles), ci (carry in) -> s (nibble sum), co (carry out).
module nibble_adder
    import nibble_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic w_c;

    always_comb begin
        w_c = ci;
        s   = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i] = a[i] ^ b[i] ^ w_c;
            w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        co = w_c;
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds WIDTH-bit operands one nibble per clock through a single nibble_adder,
// LSB nibble first, valid/ready on input and output. Optional subtract: NSAC_SUBTRACT_EN.
// Ports: clk, rst (sync, active-high), in_valid/in_ready, a, b, in_sub (optional),
//        out_valid/out_ready, sum (WIDTH+1 bits, MSB = final carry-out).
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef NSAC_SUBTRACT_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_carry;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH:0]      r_sum;
    logic                r_out_valid;

    logic [WIDTH-1:0]    w_b_in;
    logic                w_ci_init;
    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_s;
    logic                w_co;

    // Subtract is a + ~b + 1: invert b at capture, seed the carry with 1.
`ifdef NSAC_SUBTRACT_EN
    assign w_b_in    = in_sub ? ~b : b;
    assign w_ci_init = in_sub;
`else
    assign w_b_in    = b;
    assign w_ci_init = 1'b0;
`endif

    assign w_a_nib = r_a[NIBBLE_W*r_cnt +: NIBBLE_W];
    assign w_b_nib = r_b[NIBBLE_W*r_cnt +: NIBBLE_W];

    nibble_adder u_slice (
        .a  (w_a_nib),
        .b  (w_b_nib),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_ci_init;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[NIBBLE_W*r_cnt +: NIBBLE_W] <= w_s;
                    r_carry <= w_co;
                    if (r_cnt == LAST) begin
                        r_sum[WIDTH] <= w_co;
                        r_cnt        <= '0;
                        r_out_valid  <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Random and directed checks of nibble_serial_add_ctrl against an arithmetic model.
// Covers WIDTH=16 (main) and WIDTH=4 (second instance).
module tb_nibble_serial_add_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W:0]   sum;

    logic         v4 = 1'b0;
    logic         rdy4;
    logic [3:0]   a4 = '0;
    logic [3:0]   b4 = '0;
    logic         sub4 = 1'b0;
    logic         ov4;
    logic         or4 = 1'b0;
    logic [4:0]   sum4;

    int n_checks = 0;
    int n_err    = 0;
    int n_acc    = 0;
    int n_ret    = 0;
    int cyc      = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef NSAC_SUBTRACT_EN
        .in_sub    (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
    );

    nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v4),
        .in_ready  (rdy4),
        .a         (a4),
        .b         (b4),
`ifdef NSAC_SUBTRACT_EN
        .in_sub    (sub4),
`endif
        .out_valid (ov4),
        .out_ready (or4),
        .sum       (sum4)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Unsigned add, or a - b mod 2^w with the no-borrow flag in bit w.
    function automatic logic [31:0] ref_sum(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic s, input int w);
        if (s) return x + (32'd1 << w) - y;
        return x + y;
    endfunction

    logic sub_eff;
`ifdef NSAC_SUBTRACT_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_sum(32'(a), 32'(b), sub_eff, W));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0)
                    check("sb_extra_result", 32'(sb_q.size()), 32'd1);
                else
                    check("sb_sum", 32'(sum), sb_q.pop_front());
                n_ret++;
            end
        end
    end

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input int hold,
                         input logic [31:0] exp);
        int t;
        int lat;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = x;
        b = y;
        sub = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", 32'(lat), 32'(W / 4));
        check("sum", 32'(sum), exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(sum), exp);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("retire_valid", 32'(out_valid), 32'd0);
        check("retire_in_ready", 32'(in_ready), 32'd1);
        check("retire_sum_kept", 32'(sum), exp);
    endtask

    task automatic do_op4(input logic [3:0] x, input logic [3:0] y,
                          input logic [31:0] exp);
        int lat;
        check("w4_in_ready", 32'(rdy4), 32'd1);
        v4 = 1'b1;
        a4 = x;
        b4 = y;
        @(posedge clk); #1;
        v4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("w4_latency", 32'(lat), 32'd1);
        check("w4_sum", 32'(sum4), exp);
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
        check("w4_retire", 32'(ov4), 32'd0);
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;
        logic [W-1:0] va[3];
        logic [W-1:0] vb[3];
        int           acc_cyc[3];
        int           base_acc;
        int           base_ret;
        int           t;
        int           bad_valid;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_w4_in_ready", 32'(rdy4), 32'd0);
        check("rst_w4_sum", 32'(sum4), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        do_op(16'h1234, 16'h4321, 1'b0, 0, 32'h05555);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0, 32'h10000);
        x = W'($urandom);
        y = W'($urandom);
        do_op(x, y, 1'b0, 10, ref_sum(32'(x), 32'(y), 1'b0, W));

        // Abort mid-run at cnt=2.
        in_valid = 1'b1;
        a = 16'hABCD;
        b = 16'h1111;
        sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready_in_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        bad_valid = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) bad_valid++;
        end
        check("abort_no_valid", 32'(bad_valid), 32'd0);
        do_op(16'h0001, 16'h0001, 1'b0, 0, 32'h00002);

        // Back-to-back with in_valid and out_ready held high.
        for (int k = 0; k < 3; k++) begin
            va[k] = W'($urandom);
            vb[k] = W'($urandom);
        end
        base_acc = n_acc;
        base_ret = n_ret;
        out_ready = 1'b1;
        in_valid = 1'b1;
        sub = 1'b0;
        a = va[0];
        b = vb[0];
        for (int k = 0; k < 3; k++) begin
            t = 0;
            while (n_acc == base_acc + k && t < 40) begin
                @(posedge clk); #1; t++;
            end
            acc_cyc[k] = cyc;
            if (k < 2) begin
                a = va[k+1];
                b = vb[k+1];
            end else begin
                in_valid = 1'b0;
            end
            if (k > 0)
                check("b2b_gap", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'(W / 4 + 2));
        end
        t = 0;
        while (n_ret < base_ret + 3 && t < 40) begin
            @(posedge clk); #1; t++;
        end
        check("b2b_accepted", 32'(n_acc - base_acc), 32'd3);
        check("b2b_retired", 32'(n_ret - base_ret), 32'd3);
        out_ready = 1'b0;
        @(posedge clk); #1;

`ifdef NSAC_SUBTRACT_EN
        do_op(16'h0005, 16'h0007, 1'b1, 0, 32'h0FFFE);
        do_op(16'h0007, 16'h0005, 1'b1, 0, 32'h10002);
`endif

        for (int n = 0; n < 40; n++) begin
            x = W'($urandom);
            y = W'($urandom);
            if (n % 5 == 0) y = ~x;
`ifdef NSAC_SUBTRACT_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            do_op(x, y, s, int'($urandom_range(0, 3)),
                  ref_sum(32'(x), 32'(y), s, W));
        end

        do_op4(4'hF, 4'h1, 32'h10);
        for (int n = 0; n < 8; n++) begin
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            do_op4(a4, b4, ref_sum(32'(a4), 32'(b4), 1'b0, 4));
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
